// File: rtl/adc_captura_pkg.sv
// Shared definitions for the ADC capture front end and the filter top level.
// Holds the capture FSM state encoding, the default build parameters and the
// frame geometry of the 12-bit serial ADC (4 leading zeros + 12 data bits).
package adc_captura_pkg;

    localparam int CANT_BITS_DEF = 25;
    localparam int DESP_DEF      = 8;
    localparam int DIV_SCLK_DEF  = 4;
    localparam int T_MUESTRA_DEF = 2500;

    localparam int BITS_TRAMA = 16;
    // Index of the last sclk half-period of a frame (32 half-periods, 0..31).
    localparam logic [4:0] ULTIMO_MEDIO = 5'(2 * BITS_TRAMA - 1);

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        CONVIERTE = 2'd1,
        ENTREGA   = 2'd2
    } estado_t;

endpackage

// File: rtl/divisor_tick.sv
// Sample-rate divider: free-running counter 0..t_muestra-1.
// tick_o is high for the single clk cycle in which the counter sits at
// t_muestra-1, so the consumer acts on the edge where the counter wraps.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset (counter to 0)
//   tick_o  one-cycle sample tick
module divisor_tick
    import adc_captura_pkg::*;
#(
    parameter int t_muestra = T_MUESTRA_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CW = (t_muestra > 1) ? $clog2(t_muestra) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(t_muestra - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == ULTIMO);

endmodule

// File: rtl/adc_captura.sv
// ADC capture front end: on every sample tick reads one 16-bit frame from a
// 12-bit serial ADC (4 leading zeros, offset-binary code, MSB first), centres
// the code, scales it by 2^desp and hands it to the filter as a signed word.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   sdata        ADC serial data
//   cs_n         ADC chip select (active low)
//   sclk         ADC serial clock (idle high)
//   u            signed sample for the filter, held between strobes
//   rx           one-cycle strobe qualifying a new u
//   error_trama  one-cycle pulse when a frame is rejected
//   sobrecarga   sticky: a tick arrived while a conversion was in progress
module adc_captura
    import adc_captura_pkg::*;
#(
    parameter int cant_bits = CANT_BITS_DEF,
    parameter int desp      = DESP_DEF,
    parameter int div_sclk  = DIV_SCLK_DEF,
    parameter int t_muestra = T_MUESTRA_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sdata,
    output logic                        cs_n,
    output logic                        sclk,
    output logic signed [cant_bits-1:0] u,
    output logic                        rx,
    output logic                        error_trama,
    output logic                        sobrecarga
);

    localparam int DW = $clog2(div_sclk + 1);
    localparam logic [DW-1:0] DIV_ULT = DW'(div_sclk - 1);

    // Offset binary -> two's complement, then scale into the filter word.
    function automatic logic signed [cant_bits-1:0] centrar(input logic [11:0] codigo);
        logic signed [12:0]          centrado;
        logic signed [cant_bits-1:0] ext;
        centrado = $signed({1'b0, codigo}) - 13'sd2048;
        ext      = {{(cant_bits - 12){centrado[12]}}, centrado[11:0]};
        return ext <<< desp;
    endfunction

    estado_t                     estado_q, estado_d;
    logic [DW-1:0]               div_q, div_d;
    logic [4:0]                  medio_q, medio_d;
    logic                        sclk_q, sclk_d;
    logic                        cs_n_q, cs_n_d;
    logic [BITS_TRAMA-1:0]       trama_q, trama_d;
    logic signed [cant_bits-1:0] u_q, u_d;
    logic                        rx_q, rx_d;
    logic                        err_q, err_d;
    logic                        sobre_q, sobre_d;
    logic                        tick;

    divisor_tick #(
        .t_muestra(t_muestra)
    ) u_divisor_tick (
        .clk_i (clk),
        .rst_ni(rst),
        .tick_o(tick)
    );

    always_comb begin
        estado_d = estado_q;
        div_d    = div_q;
        medio_d  = medio_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        trama_d  = trama_q;
        u_d      = u_q;
        rx_d     = 1'b0;
        err_d    = 1'b0;
        sobre_d  = sobre_q;

        // A tick during a frame is dropped; the frame keeps its full length.
        if (tick && (estado_q != ESPERA)) begin
            sobre_d = 1'b1;
        end

        case (estado_q)
            ESPERA: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if (tick) begin
                    estado_d = CONVIERTE;
                    cs_n_d   = 1'b0;
                    sclk_d   = 1'b0;
                    div_d    = '0;
                    medio_d  = '0;
                end
            end
            CONVIERTE: begin
                if (div_q == DIV_ULT) begin
                    div_d = '0;
                    // After the 32nd half-period sclk is already high: just end the frame.
                    if (medio_q == ULTIMO_MEDIO) begin
                        estado_d = ENTREGA;
                        cs_n_d   = 1'b1;
                        sclk_d   = 1'b1;
                    end else begin
                        sclk_d  = ~sclk_q;
                        medio_d = medio_q + 5'd1;
                        // sclk about to rise: capture the bit the ADC is presenting.
                        if (!sclk_q) begin
                            trama_d = {trama_q[BITS_TRAMA-2:0], sdata};
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            ENTREGA: begin
                estado_d = ESPERA;
                if (trama_q[15:12] == 4'b0000) begin
                    u_d  = centrar(trama_q[11:0]);
                    rx_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q <= ESPERA;
            div_q    <= '0;
            medio_q  <= '0;
            sclk_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            trama_q  <= '0;
            u_q      <= '0;
            rx_q     <= 1'b0;
            err_q    <= 1'b0;
            sobre_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            div_q    <= div_d;
            medio_q  <= medio_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            trama_q  <= trama_d;
            u_q      <= u_d;
            rx_q     <= rx_d;
            err_q    <= err_d;
            sobre_q  <= sobre_d;
        end
    end

    assign cs_n        = cs_n_q;
    assign sclk        = sclk_q;
    assign u           = u_q;
    assign rx          = rx_q;
    assign error_trama = err_q;
    assign sobrecarga  = sobre_q;

endmodule

// File: tb/tb_adc_captura.sv
module tb_adc_captura;

    localparam int DIV  = 4;
    localparam int T_A  = 300;
    localparam int T_B  = 100;
    localparam int DESP = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // DUT A: normal sample period
    logic               sdata_a = 1'b0;
    logic               cs_n_a, sclk_a, rx_a, err_a, sobre_a;
    logic signed [24:0] u_a;
    // DUT B: sample period shorter than a conversion (overload build)
    logic               sdata_b = 1'b0;
    logic               cs_n_b, sclk_b, rx_b, err_b, sobre_b;
    logic signed [24:0] u_b;

    adc_captura #(.cant_bits(25), .desp(DESP), .div_sclk(DIV), .t_muestra(T_A)) dut_a (
        .clk(clk), .rst(rst), .sdata(sdata_a), .cs_n(cs_n_a), .sclk(sclk_a),
        .u(u_a), .rx(rx_a), .error_trama(err_a), .sobrecarga(sobre_a));

    adc_captura #(.cant_bits(25), .desp(DESP), .div_sclk(DIV), .t_muestra(T_B)) dut_b (
        .clk(clk), .rst(rst), .sdata(sdata_b), .cs_n(cs_n_b), .sclk(sclk_b),
        .u(u_b), .rx(rx_b), .error_trama(err_b), .sobrecarga(sobre_b));

    // ADC model for DUT A: MSB presented when cs_n falls, next bit after each sclk rise.
    logic [15:0] frame_a = 16'h0;
    int          idx_a   = 15;
    always @(negedge cs_n_a) begin
        idx_a   = 15;
        sdata_a = frame_a[15];
    end
    always @(posedge sclk_a) begin
        if (cs_n_a === 1'b0 && idx_a > 0) begin
            idx_a--;
            sdata_a = frame_a[idx_a];
        end
    end

    // Monitors: rx never two cycles in a row; cs_n low length of DUT B frames.
    int   dbl = 0;
    logic prev_rx_a = 1'b0, prev_rx_b = 1'b0;
    int   b_run = 0, b_last_len = 0;
    always @(negedge clk) begin
        if (rx_a === 1'b1 && prev_rx_a === 1'b1) dbl++;
        if (rx_b === 1'b1 && prev_rx_b === 1'b1) dbl++;
        prev_rx_a = rx_a;
        prev_rx_b = rx_b;
        if (cs_n_b === 1'b0) b_run++;
        else if (b_run != 0) begin
            b_last_len = b_run;
            b_run      = 0;
        end
    end

    int checks = 0, failures = 0;
    int last_fall = 0;
    bit have_last = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Reference: centre the 12-bit offset-binary code and scale by 2^DESP.
    function automatic logic [24:0] model_u(input logic [15:0] f, input logic [24:0] prev);
        int v;
        if (f[15:12] != 4'h0) return prev;
        v = (int'(f[11:0]) - 2048) * (1 << DESP);
        return v[24:0];
    endfunction

    task automatic wait_fall(output int n);
        n = 0;
        while (cs_n_a !== 1'b0 && n < T_A + 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called at the first negedge where cs_n is observed low.
    task automatic finish_frame(input string nm, input logic xrx, input logic xerr, input logic [24:0] xu);
        int   low, rises, falls, nrx, nerr;
        logic prev_s;
        low = 0; rises = 0; falls = 0; prev_s = 1'b1;
        while (cs_n_a === 1'b0 && low < 40 * DIV) begin
            if (sclk_a !== prev_s) begin
                if (sclk_a === 1'b1) rises++;
                else falls++;
            end
            prev_s = sclk_a;
            low++;
            @(negedge clk);
        end
        nrx = 0; nerr = 0;
        for (int k = 0; k < 4; k++) begin
            if (rx_a === 1'b1) nrx++;
            if (err_a === 1'b1) nerr++;
            @(negedge clk);
        end
        chk({nm, "_cs_low"}, 64'(low), 64'(32 * DIV));
        chk({nm, "_sclk_rises"}, 64'(rises), 64'd16);
        chk({nm, "_sclk_falls"}, 64'(falls), 64'd16);
        chk({nm, "_rx_pulses"}, 64'(nrx), {63'b0, xrx});
        chk({nm, "_err_pulses"}, 64'(nerr), {63'b0, xerr});
        chk({nm, "_u"}, {39'b0, u_a}, {39'b0, xu});
    endtask

    task automatic run_frame(input string nm, input logic [15:0] f, input logic xrx, input logic xerr,
                             input logic [24:0] xu);
        int n;
        frame_a = f;
        wait_fall(n);
        if (cs_n_a !== 1'b0) begin
            chk({nm, "_cs_fall"}, {63'b0, cs_n_a}, 64'd0);
            return;
        end
        if (have_last) chk({nm, "_period"}, 64'(cyc - last_fall), 64'(T_A));
        last_fall = cyc;
        have_last = 1'b1;
        finish_frame(nm, xrx, xerr, xu);
    endtask

    typedef struct {
        logic [15:0] trama;
        logic        xrx;
        logic        xerr;
        logic [24:0] xu;
    } vec_t;
    vec_t tabla[6];

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f;
        logic [24:0] prev_u, xu;
        int          n, r, nrx;
        logic        prev_s;

        tabla[0] = '{16'h0800, 1'b1, 1'b0, 25'h0000000};
        tabla[1] = '{16'h0FFF, 1'b1, 1'b0, 25'h007FF00};
        tabla[2] = '{16'h0000, 1'b1, 1'b0, 25'h1F80000};
        tabla[3] = '{16'h8123, 1'b0, 1'b1, 25'h1F80000};
        tabla[4] = '{16'h0801, 1'b1, 1'b0, 25'h0000100};
        tabla[5] = '{16'h07FF, 1'b1, 1'b0, 25'h1FFFF00};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cs_n", {63'b0, cs_n_a}, 64'd1);
        chk("reset_sclk", {63'b0, sclk_a}, 64'd1);
        chk("reset_u", {39'b0, u_a}, 64'd0);
        chk("reset_rx", {63'b0, rx_a}, 64'd0);
        chk("reset_err", {63'b0, err_a}, 64'd0);
        chk("reset_sobre", {63'b0, sobre_a}, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("tab%0d", i), tabla[i].trama, tabla[i].xrx, tabla[i].xerr, tabla[i].xu);
        end

        prev_u = tabla[5].xu;
        for (int i = 0; i < 12; i++) begin
            f = 16'($urandom);
            if ($urandom_range(0, 3) != 0) f[15:12] = 4'h0;
            xu = model_u(f, prev_u);
            run_frame($sformatf("rnd%0d_%04h", i, f), f, (f[15:12] == 4'h0), (f[15:12] != 4'h0), xu);
            prev_u = xu;
        end

        chk("b_sobrecarga", {63'b0, sobre_b}, 64'd1);
        chk("b_cs_low", 64'(b_last_len), 64'(32 * DIV));
        chk("b_u", {39'b0, u_b}, {39'b0, 25'h1F80000});
        chk("a_no_sobrecarga", {63'b0, sobre_a}, 64'd0);

        // Reset in the middle of a frame, at the 7th sclk rise.
        frame_a = 16'h0ABC;
        wait_fall(n);
        r = 0; n = 0; prev_s = sclk_a;
        while (r < 7 && n < 400) begin
            @(negedge clk);
            n++;
            if (sclk_a !== prev_s && sclk_a === 1'b1) r++;
            prev_s = sclk_a;
        end
        chk("abort_rises", 64'(r), 64'd7);
        #2 rst = 1'b0;
        #1;
        chk("abort_cs_n", {63'b0, cs_n_a}, 64'd1);
        chk("abort_sclk", {63'b0, sclk_a}, 64'd1);
        chk("abort_u", {39'b0, u_a}, 64'd0);
        chk("abort_rx", {63'b0, rx_a}, 64'd0);
        chk("abort_sobre_b", {63'b0, sobre_b}, 64'd0);
        chk("abort_u_b", {39'b0, u_b}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        frame_a = 16'h0C35;
        n = 0; nrx = 0;
        while (cs_n_a !== 1'b0 && n < T_A + 20) begin
            @(negedge clk);
            n++;
            if (rx_a === 1'b1) nrx++;
        end
        chk("post_reset_first_tick", 64'(n), 64'(T_A));
        chk("post_reset_no_rx", 64'(nrx), 64'd0);
        last_fall = cyc;
        have_last = 1'b1;
        finish_frame("post_reset", 1'b1, 1'b0, model_u(16'h0C35, 25'h0));
        run_frame("post_reset2", 16'h0123, 1'b1, 1'b0, model_u(16'h0123, 25'h0));

        repeat (450) @(negedge clk);
        chk("b_sobrecarga_again", {63'b0, sobre_b}, 64'd1);
        chk("b_cs_low_again", 64'(b_last_len), 64'(32 * DIV));
        chk("rx_double", 64'(dbl), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
